// File: rtl/regfile_pkg.sv
// Shared encodings for the banked register file: register operations and
// save/restore controller states.
package regfile_pkg;

  typedef enum logic [2:0] {
    FUN_DEC  = 3'b000,
    FUN_INC  = 3'b001,
    FUN_LOAD = 3'b010,
    FUN_CLR  = 3'b011,
    FUN_SHL  = 3'b100,
    FUN_SHR  = 3'b101,
    FUN_ROL  = 3'b110,
    FUN_HOLD = 3'b111
  } fun_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_SAVE    = 2'b01,
    ST_RESTORE = 2'b10
  } state_e;

endpackage

// File: rtl/param_register.sv
// WIDTH-bit register with an enable and an eight-way operation select.
// Clear on a synchronous active-low reset.
module param_register
  import regfile_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] I,
  input  logic             E,
  input  logic [2:0]       FunSel,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;

  always_comb begin
    q_next = q_reg;
    case (FunSel)
      FUN_DEC:  q_next = q_reg - 1'b1;
      FUN_INC:  q_next = q_reg + 1'b1;
      FUN_LOAD: q_next = I;
      FUN_CLR:  q_next = '0;
      FUN_SHL:  q_next = {q_reg[WIDTH-2:0], 1'b0};
      FUN_SHR:  q_next = {1'b0, q_reg[WIDTH-1:1]};
      FUN_ROL:  q_next = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
      default:  q_next = q_reg;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      q_reg <= '0;
    end else if (E) begin
      q_reg <= q_next;
    end
  end

  assign Q = q_reg;

endmodule

// File: rtl/banked_register_file.sv
// General and scratch register banks with two combinational read ports, plus a
// shadow bank that the general registers are copied to/from one per cycle.
module banked_register_file
  import regfile_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREG  = 4,
  parameter int NSCR  = 4,
  localparam int SELW = ((NREG + NSCR) > 1) ? $clog2(NREG + NSCR) : 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] I,
  input  logic [NREG-1:0]  RegSel,
  input  logic [NSCR-1:0]  ScrSel,
  input  logic [2:0]       FunSel,
  input  logic [SELW-1:0]  OutASel,
  input  logic [SELW-1:0]  OutBSel,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB,
  input  logic             SaveReq,
  input  logic             RestoreReq,
  output logic             Busy,
  output logic             Done
);

  localparam int NTOT = NREG + NSCR;
  localparam int IDXW = (NREG > 1) ? $clog2(NREG) : 1;

  state_e           state_reg, state_next;
  logic [IDXW-1:0]  idx_reg, idx_next;
  logic             done_reg, done_next;
  logic             last_idx;
  logic [WIDTH-1:0] shadow_reg [NREG];
  logic [WIDTH-1:0] q_all [NTOT];

  assign last_idx = (idx_reg == IDXW'(NREG - 1));

  genvar gi;
  generate
    // General registers: frozen during SAVE, loaded from the shadow bank
    // one index per cycle during RESTORE.
    for (gi = 0; gi < NREG; gi++) begin : g_gen
      logic             en;
      logic [2:0]       fs;
      logic [WIDTH-1:0] din;
      logic [WIDTH-1:0] q;

      always_comb begin
        en  = RegSel[NREG-1-gi];
        fs  = FunSel;
        din = I;
        if (state_reg == ST_SAVE) begin
          en = 1'b0;
        end else if (state_reg == ST_RESTORE) begin
          en  = (idx_reg == IDXW'(gi));
          fs  = FUN_LOAD;
          din = shadow_reg[gi];
        end
      end

      param_register #(.WIDTH(WIDTH)) u_reg (
        .Clock  (Clock),
        .Reset  (Reset),
        .I      (din),
        .E      (en),
        .FunSel (fs),
        .Q      (q)
      );
      assign q_all[gi] = q;
    end

    for (gi = 0; gi < NSCR; gi++) begin : g_scr
      logic [WIDTH-1:0] q;

      param_register #(.WIDTH(WIDTH)) u_reg (
        .Clock  (Clock),
        .Reset  (Reset),
        .I      (I),
        .E      (ScrSel[NSCR-1-gi]),
        .FunSel (FunSel),
        .Q      (q)
      );
      assign q_all[NREG+gi] = q;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    done_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        idx_next = '0;
        if (SaveReq) begin
          state_next = ST_SAVE;
        end else if (RestoreReq) begin
          state_next = ST_RESTORE;
        end
      end
      ST_SAVE, ST_RESTORE: begin
        if (last_idx) begin
          state_next = ST_IDLE;
          idx_next   = '0;
          done_next  = 1'b1;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        idx_next   = '0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      done_reg  <= done_next;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      for (int k = 0; k < NREG; k++) begin
        shadow_reg[k] <= '0;
      end
    end else if (state_reg == ST_SAVE) begin
      shadow_reg[idx_reg] <= q_all[idx_reg];
    end
  end

  // Selects at or beyond NTOT match no entry and fall through to zero.
  always_comb begin
    OutA = '0;
    OutB = '0;
    for (int k = 0; k < NTOT; k++) begin
      if (int'(OutASel) == k) OutA = q_all[k];
      if (int'(OutBSel) == k) OutB = q_all[k];
    end
  end

  assign Busy = (state_reg != ST_IDLE);
  assign Done = done_reg;

endmodule

// File: tb/tb_banked_register_file.sv
// Directed bench for banked_register_file: arithmetic/shift ops, save/restore
// sequencing, request arbitration, reset abort and out-of-range reads.
module tb_banked_register_file;
  import regfile_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [31:0] I;
  logic [3:0]  RegSel, ScrSel;
  logic [2:0]  FunSel;
  logic [2:0]  OutASel, OutBSel;
  logic [31:0] OutA, OutB;
  logic        SaveReq, RestoreReq, Busy, Done;

  logic [2:0]  b_regsel, b_scrsel, b_outasel, b_outbsel;
  logic [31:0] b_outa, b_outb;
  logic        b_save, b_restore, b_busy, b_done;

  int checks = 0;
  int passed = 0;

  always #5 Clock = ~Clock;

  banked_register_file #(.WIDTH(32), .NREG(4), .NSCR(4)) dut (
    .Clock(Clock), .Reset(Reset), .I(I), .RegSel(RegSel), .ScrSel(ScrSel),
    .FunSel(FunSel), .OutASel(OutASel), .OutBSel(OutBSel), .OutA(OutA),
    .OutB(OutB), .SaveReq(SaveReq), .RestoreReq(RestoreReq), .Busy(Busy),
    .Done(Done)
  );

  banked_register_file #(.WIDTH(32), .NREG(3), .NSCR(3)) dut_b (
    .Clock(Clock), .Reset(Reset), .I(I), .RegSel(b_regsel), .ScrSel(b_scrsel),
    .FunSel(FunSel), .OutASel(b_outasel), .OutBSel(b_outbsel), .OutA(b_outa),
    .OutB(b_outb), .SaveReq(b_save), .RestoreReq(b_restore), .Busy(b_busy),
    .Done(b_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
      $display("ok   %-16s %h", tag, obs);
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled at the falling edge.
  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic idle_inputs();
    RegSel = '0; ScrSel = '0; FunSel = FUN_HOLD; I = '0;
    SaveReq = 1'b0; RestoreReq = 1'b0;
    b_regsel = '0; b_scrsel = '0;
  endtask

  task automatic op(input logic [3:0] rs, input logic [3:0] ss,
                    input logic [2:0] fs, input logic [31:0] d);
    RegSel = rs; ScrSel = ss; FunSel = fs; I = d;
    tick();
    idle_inputs();
  endtask

  task automatic chk_reg(input string tag, input logic [2:0] sel, input logic [31:0] exp);
    OutASel = sel; OutBSel = sel;
    #1;
    chk({tag, "/A"}, OutA, exp);
    chk({tag, "/B"}, OutB, exp);
  endtask

  task automatic chk_busy_run(input string tag);
    for (int c = 0; c < 4; c++) begin
      chk({tag, " busy"}, {31'b0, Busy}, 32'd1);
      tick();
    end
    chk({tag, " done"}, {31'b0, Done}, 32'd1);
    chk({tag, " idle"}, {31'b0, Busy}, 32'd0);
  endtask

  initial begin
    Reset = 1'b0;
    OutASel = '0; OutBSel = '0; b_outasel = '0; b_outbsel = '0;
    b_save = 1'b0; b_restore = 1'b0;
    idle_inputs();
    tick(); tick();
    chk_reg("rst R1", 3'd0, 32'h0);
    chk("rst busy", {31'b0, Busy}, 32'd0);
    chk("rst done", {31'b0, Done}, 32'd0);
    Reset = 1'b1;
    tick();

    // Out-of-range reads on the 3+3 instance
    b_regsel = 3'b111; b_scrsel = 3'b111; FunSel = FUN_LOAD; I = 32'h5A5A5A5A;
    tick();
    idle_inputs();
    b_outasel = 3'd5; b_outbsel = 3'd0; #1;
    chk("B S3", b_outa, 32'h5A5A5A5A);
    chk("B R1", b_outb, 32'h5A5A5A5A);
    b_outasel = 3'd6; b_outbsel = 3'd7; #1;
    chk("B sel6", b_outa, 32'h0);
    chk("B sel7", b_outb, 32'h0);

    // Wrap-around increment/decrement
    op(4'b1000, 4'b0000, FUN_LOAD, 32'hFFFFFFFF);
    op(4'b1000, 4'b0000, FUN_INC, 32'h0);
    chk_reg("inc wrap", 3'd0, 32'h00000000);
    op(4'b1000, 4'b0000, FUN_DEC, 32'h0);
    chk_reg("dec wrap", 3'd0, 32'hFFFFFFFF);

    // Shifts and rotate on R2
    op(4'b0100, 4'b0000, FUN_LOAD, 32'h80000001);
    op(4'b0100, 4'b0000, FUN_SHL, 32'h0);
    chk_reg("shl", 3'd1, 32'h00000002);
    op(4'b0100, 4'b0000, FUN_LOAD, 32'h80000001);
    op(4'b0100, 4'b0000, FUN_SHR, 32'h0);
    chk_reg("shr", 3'd1, 32'h40000000);
    op(4'b0100, 4'b0000, FUN_LOAD, 32'h80000001);
    op(4'b0100, 4'b0000, FUN_ROL, 32'h0);
    chk_reg("rol", 3'd1, 32'h00000003);
    chk_reg("R1 held", 3'd0, 32'hFFFFFFFF);
    op(4'b0100, 4'b0000, FUN_CLR, 32'h0);
    chk_reg("clr", 3'd1, 32'h0);

    // Save with RegSel/ScrSel activity and an ignored RestoreReq
    op(4'b1000, 4'b0000, FUN_LOAD, 32'd1);
    op(4'b0100, 4'b0000, FUN_LOAD, 32'd2);
    op(4'b0010, 4'b0000, FUN_LOAD, 32'd3);
    op(4'b0001, 4'b0000, FUN_LOAD, 32'd4);
    SaveReq = 1'b1;
    tick();
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      idle_inputs();
      chk("save busy", {31'b0, Busy}, 32'd1);
      chk("save nodone", {31'b0, Done}, 32'd0);
      case (c)
        0: begin RegSel = 4'b1111; FunSel = FUN_LOAD; I = 32'h0000DEAD; end
        1: begin ScrSel = 4'b1000; FunSel = FUN_LOAD; I = 32'h0000BEEF; end
        2: RestoreReq = 1'b1;
        default: ;
      endcase
      tick();
    end
    idle_inputs();
    chk("save done", {31'b0, Done}, 32'd1);
    chk("save idle", {31'b0, Busy}, 32'd0);
    tick();
    chk("done pulse", {31'b0, Done}, 32'd0);
    chk("no queued", {31'b0, Busy}, 32'd0);
    chk_reg("frz R1", 3'd0, 32'd1);
    chk_reg("frz R4", 3'd3, 32'd4);
    chk_reg("S1 beef", 3'd4, 32'h0000BEEF);

    // Clear and restore
    op(4'b1111, 4'b0000, FUN_CLR, 32'h0);
    chk_reg("cleared R2", 3'd1, 32'h0);
    RestoreReq = 1'b1;
    tick();
    idle_inputs();
    chk_busy_run("rest");
    chk_reg("rest R1", 3'd0, 32'd1);
    chk_reg("rest R2", 3'd1, 32'd2);
    chk_reg("rest R3", 3'd2, 32'd3);
    chk_reg("rest R4", 3'd3, 32'd4);
    tick();

    // Both requests: save wins; restore accepted in the Done cycle
    op(4'b1000, 4'b0000, FUN_LOAD, 32'h11);
    SaveReq = 1'b1; RestoreReq = 1'b1;
    tick();
    idle_inputs();
    chk_busy_run("both");
    chk_reg("both R1", 3'd0, 32'h11);
    RegSel = 4'b1000; FunSel = FUN_LOAD; I = 32'h99; RestoreReq = 1'b1;
    tick();
    idle_inputs();
    chk("b2b busy", {31'b0, Busy}, 32'd1);
    chk_reg("b2b R1 ld", 3'd0, 32'h99);
    tick(); tick(); tick(); tick();
    chk("b2b done", {31'b0, Done}, 32'd1);
    chk_reg("b2b R1", 3'd0, 32'h11);
    chk_reg("b2b R2", 3'd1, 32'd2);
    tick();

    // Reset during the second RESTORE cycle
    RestoreReq = 1'b1;
    tick();
    idle_inputs();
    tick();
    chk("abort pre", {31'b0, Busy}, 32'd1);
    Reset = 1'b0;
    tick();
    chk("abort busy", {31'b0, Busy}, 32'd0);
    chk("abort done", {31'b0, Done}, 32'd0);
    chk_reg("abort R1", 3'd0, 32'h0);
    chk_reg("abort R4", 3'd3, 32'h0);
    chk_reg("abort S1", 3'd4, 32'h0);
    Reset = 1'b1;
    tick();
    chk("abort nodone", {31'b0, Done}, 32'd0);
    op(4'b1111, 4'b0000, FUN_LOAD, 32'd5);
    chk_reg("pre R3", 3'd2, 32'd5);
    RestoreReq = 1'b1;
    tick();
    idle_inputs();
    chk_busy_run("shd");
    chk_reg("shd R1", 3'd0, 32'h0);
    chk_reg("shd R4", 3'd3, 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
